// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Memory end of the instruction-fetch handshake. A word read is accepted
// from IDLE when instr_read is high at a clock edge. The word is read from
// an on-chip array that can be preloaded, and it is returned with a fixed
// latency as a one-cycle instr_mem_resp strobe. Bad addresses and requester
// protocol violations are reported on read_error in the response cycle.
//
// Parameters:
//   DEPTH_LOG2 : log2 of the array depth in 32-bit words
//   BASE_ADDR  : byte address of word 0
//   LATENCY    : cycles from the accepting edge to the response cycle (1..15)
//
// Ports:
//   clk               : clock
//   reset_n           : asynchronous active-low reset
//   instr_read        : read request, held by the requester until the response
//   instr_mem_address : byte address, stable while the request is pending
//   instr_mem_resp    : one-cycle response strobe
//   instr_mem_rdata   : instruction word, non-zero only in the response cycle
//   read_error        : one-cycle error strobe, coincident with the response
//   load_we           : preload write enable, honoured in every state
//   load_addr         : preload word index
//   load_data         : preload word
//   busy              : high while a request is in flight (BUSY and RESP)
//
// Optional feature, selected by the macro IMEM_RESP_STALL_EN:
//   A 16-bit LFSR adds 0..3 random extra cycles to each request's latency.
//   This exercises the requester's tolerance of stalls.
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0060,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_read,
  input  logic [31:0]           instr_mem_address,
  output logic                  instr_mem_resp,
  output logic [31:0]           instr_mem_rdata,
  output logic                  read_error,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  busy
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          DEPTH    = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] addr_reg;
  logic        bad_reg;
  logic        viol_reg;
  logic        resp_reg;
  logic        err_reg;
  logic        busy_reg;
  logic [31:0] word_reg;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]           offset;
  logic                  addr_bad;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  accept;
  logic                  viol_now;
  logic [4:0]            total_lat;

  // Decode the address for the array. Every bit of the offset above the
  // array span must be zero. addr < BASE_ADDR wraps the offset, so that
  // case is checked separately.
  assign offset   = instr_mem_address - BASE_ADDR;
  assign addr_bad = (instr_mem_address[1:0] != 2'b00) ||
                    (instr_mem_address < BASE_ADDR) ||
                    ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign rd_idx   = offset[DEPTH_LOG2+1:2];

  assign accept   = (state == IDLE) && instr_read;
  assign viol_now = (state == BUSY) &&
                    (!instr_read || (instr_mem_address != addr_reg));

`ifdef IMEM_RESP_STALL_EN
  // Fibonacci LFSR with taps 16,14,13,11. It runs freely every edge.
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign total_lat = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign total_lat = 5'(LATENCY);
`endif

  // Array with a registered read port. The port is enabled only at the
  // accepting edge, so the latched word cannot change later, even when a
  // preload writes the same index. A write on the accepting edge itself is
  // read-before-write.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_reg <= mem[rd_idx];
    end
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      addr_reg <= 32'd0;
      bad_reg  <= 1'b0;
      viol_reg <= 1'b0;
      resp_reg <= 1'b0;
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      resp_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_read) begin
            addr_reg <= instr_mem_address;
            bad_reg  <= addr_bad;
            viol_reg <= 1'b0;
            busy_reg <= 1'b1;
            cnt      <= total_lat - 5'd1;
            if (total_lat == 5'd1) begin
              state    <= RESP;
              resp_reg <= 1'b1;
              err_reg  <= addr_bad;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 5'd1;
          if (viol_now) begin
            viol_reg <= 1'b1;
          end
          // A violation seen in the last BUSY cycle still counts. The two
          // error sources are ORed, so the error is always one pulse.
          if (cnt == 5'd1) begin
            state    <= RESP;
            resp_reg <= 1'b1;
            err_reg  <= bad_reg | viol_reg | viol_now;
          end
        end
        RESP: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign instr_mem_resp = resp_reg;
  assign read_error     = err_reg;
  assign busy           = busy_reg;

  // Driven only from flops. The value is zero outside the response cycle.
  // A bad address returns a NOP in place of the array word.
  assign instr_mem_rdata = resp_reg ? (bad_reg ? NOP_WORD : word_reg) : 32'd0;

endmodule
